// File: rtl/snn_mem_pkg.sv
// Shared types for the double-buffered memory: sweep FSM state encoding
// and a sizing helper for the saturating stream counter.
package snn_mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } dbuf_state_t;

  // Bits needed to hold the values 0..m inclusive.
  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dbuf_mem_bank.sv
// M x N register array with one random-access write port, a whole-bank
// parallel load and a flattened view of every entry.
module dbuf_mem_bank #(
  parameter int M  = 320,
  parameter int N  = 8,
  localparam int AW = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [N-1:0]    i_wr_data,
  input  logic            i_load,
  input  logic [M*N-1:0]  i_load_data,
  output logic [M*N-1:0]  o_flat
);

  logic [M*N-1:0] r_mem;

  // Storage: bulk load wins over the single-entry write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem <= '0;
    end else if (i_load) begin
      r_mem <= i_load_data;
    end else if (i_wr_en) begin
      for (int i = 0; i < M; i++) begin
        if (i_wr_addr == AW'(i)) r_mem[i*N +: N] <= i_wr_data;
      end
    end
  end

  assign o_flat = r_mem;

endmodule

// File: rtl/dbuf_memory.sv
// Double-buffered M x N memory: writes and stream loads fill a shadow bank,
// commit copies shadow to the active (read) bank in a single edge, and a
// clear pulse sweeps the shadow bank to zero one entry per cycle.
module dbuf_memory
  import snn_mem_pkg::*;
#(
  parameter int M  = 320,
  parameter int N  = 8,
  localparam int AW = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [N-1:0]    wr_data,
  input  logic            st_valid,
  input  logic [N-1:0]    st_data,
  output logic            st_ready,
  input  logic            clear,
  input  logic            commit,
  input  logic [AW-1:0]   rd_addr,
  output logic [N-1:0]    rd_data,
  output logic [M*N-1:0]  all_data_out,
  output logic            busy,
  output logic            loaded
);

  localparam int             CW       = cnt_width(M);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(M);
  localparam logic [AW-1:0]  LAST_IDX = AW'(M - 1);
  localparam logic [AW:0]    M_EXT    = (AW + 1)'(M);

  dbuf_state_t     r_state;
  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   r_st_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_commit_pend;

  logic            w_busy;
  logic            w_wr_ok;
  logic            w_st_accept;
  logic            w_do_copy;
  logic            w_sh_we;
  logic [AW-1:0]   w_sh_addr;
  logic [N-1:0]    w_sh_data;
  logic [M*N-1:0]  w_shadow_flat;
  logic [M*N-1:0]  w_active_flat;

  assign w_busy      = (r_state == ST_CLEAR);
  assign busy        = w_busy;
  assign st_ready    = !w_busy && !wr_en;
  assign w_st_accept = st_valid && st_ready;
  // Out-of-range addresses are compared one bit wider so M need not be a power of two.
  assign w_wr_ok     = wr_en && !w_busy && ({1'b0, wr_addr} < M_EXT);
  assign loaded      = (r_cnt == CNT_MAX);
  // A commit deferred by the sweep fires on the first idle cycle afterwards.
  assign w_do_copy   = !w_busy && (commit || r_commit_pend);

  // Shadow write-port source: sweep, then random access, then stream.
  always_comb begin
    w_sh_we   = 1'b0;
    w_sh_addr = '0;
    w_sh_data = '0;
    if (w_busy) begin
      w_sh_we   = 1'b1;
      w_sh_addr = r_ptr;
    end else if (w_wr_ok) begin
      w_sh_we   = 1'b1;
      w_sh_addr = wr_addr;
      w_sh_data = wr_data;
    end else if (w_st_accept) begin
      w_sh_we   = 1'b1;
      w_sh_addr = r_st_ptr;
      w_sh_data = st_data;
    end
  end

  // Sweep FSM, deferred-commit flag and stream pointer/count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_st_ptr      <= '0;
      r_cnt         <= '0;
      r_commit_pend <= 1'b0;
    end else begin
      if (w_do_copy)             r_commit_pend <= 1'b0;
      else if (commit && w_busy) r_commit_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
          end
        end
        ST_CLEAR: begin
          if (clear) begin
            r_ptr <= '0;
          end else if (r_ptr == LAST_IDX) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ptr   <= '0;
        end
      endcase

      if (clear) begin
        r_st_ptr <= '0;
        r_cnt    <= '0;
      end else if (w_st_accept) begin
        r_st_ptr <= (r_st_ptr == LAST_IDX) ? '0 : r_st_ptr + AW'(1);
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  dbuf_mem_bank #(.M(M), .N(N)) u_shadow (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (w_sh_we),
    .i_wr_addr   (w_sh_addr),
    .i_wr_data   (w_sh_data),
    .i_load      (1'b0),
    .i_load_data ('0),
    .o_flat      (w_shadow_flat)
  );

  // The copy samples the shadow contents before this edge's write lands.
  dbuf_mem_bank #(.M(M), .N(N)) u_active (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (1'b0),
    .i_wr_addr   ('0),
    .i_wr_data   ('0),
    .i_load      (w_do_copy),
    .i_load_data (w_shadow_flat),
    .o_flat      (w_active_flat)
  );

  assign all_data_out = w_active_flat;

  // Read mux over the active bank; addresses past the last entry read zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < M; i++) begin
      if (rd_addr == AW'(i)) rd_data = w_active_flat[i*N +: N];
    end
  end

endmodule

// File: tb/tb_dbuf_memory.sv
// Directed and randomized bench for dbuf_memory (M=6, N=8) with a
// behavioural model feeding a scoreboard queue.
module tb_dbuf_memory;

  localparam int M  = 6;
  localparam int N  = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [N-1:0]    wr_data = '0;
  logic            st_valid = 1'b0;
  logic [N-1:0]    st_data = '0;
  logic            st_ready;
  logic            clear = 1'b0;
  logic            commit = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic [N-1:0]    rd_data;
  logic [M*N-1:0]  all_data_out;
  logic            busy;
  logic            loaded;

  dbuf_memory #(.M(M), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .st_valid     (st_valid),
    .st_data      (st_data),
    .st_ready     (st_ready),
    .clear        (clear),
    .commit       (commit),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .all_data_out (all_data_out),
    .busy         (busy),
    .loaded       (loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [M*N-1:0] act;
    logic           ld;
    logic           bz;
    logic           sr;
    logic [N-1:0]   rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [N-1:0] m_sh[M];
  logic [N-1:0] m_act[M];
  int          m_ptr = 0;
  int          m_st_ptr = 0;
  int          m_cnt = 0;
  bit          m_busy = 1'b0;
  bit          m_pend = 1'b0;
  int          n_vec = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, push its prediction,
  // then pop and compare after the edge.
  task automatic tick(input bit rst, input bit we, input int wa, input int wd,
                      input bit sv, input int sd, input bit clr, input bit cmt,
                      input int ra);
    exp_t         e;
    logic [N-1:0] snap[M];
    bit           acc;
    bit           cp;
    reset = rst; wr_en = we; wr_addr = AW'(wa); wr_data = N'(wd);
    st_valid = sv; st_data = N'(sd); clear = clr; commit = cmt; rd_addr = AW'(ra);
    if (!rst) begin
      for (int i = 0; i < M; i++) begin m_sh[i] = '0; m_act[i] = '0; end
      m_ptr = 0; m_st_ptr = 0; m_cnt = 0; m_busy = 1'b0; m_pend = 1'b0;
    end else begin
      snap = m_sh;
      cp   = !m_busy && (cmt || m_pend);
      acc  = 1'b0;
      if (m_busy) m_sh[m_ptr] = '0;
      else if (we) begin
        if (wa < M) m_sh[wa] = N'(wd);
      end else if (sv) begin
        m_sh[m_st_ptr] = N'(sd);
        acc = 1'b1;
      end
      if (cp) m_act = snap;
      if (cp) m_pend = 1'b0;
      else if (cmt && m_busy) m_pend = 1'b1;
      if (clr) begin m_st_ptr = 0; m_cnt = 0; end
      else if (acc) begin
        m_st_ptr = (m_st_ptr + 1) % M;
        if (m_cnt < M) m_cnt++;
      end
      if (clr) begin m_busy = 1'b1; m_ptr = 0; end
      else if (m_busy) begin
        if (m_ptr == M - 1) begin m_busy = 1'b0; m_ptr = 0; end
        else m_ptr++;
      end
    end
    for (int i = 0; i < M; i++) e.act[i*N +: N] = m_act[i];
    e.ld = (m_cnt == M);
    e.bz = m_busy;
    e.sr = !m_busy && !we;
    e.rd = (ra < M) ? m_act[ra] : '0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_all_data_out", 64'(all_data_out), 64'(e.act));
    chk("sb_loaded",       64'(loaded),       64'(e.ld));
    chk("sb_busy",         64'(busy),         64'(e.bz));
    chk("sb_st_ready",     64'(st_ready),     64'(e.sr));
    chk("sb_rd_data",      64'(rd_data),      64'(e.rd));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;

    // Reset state
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_all_data", 64'(all_data_out), 64'h0);
    chk("rst_busy",     64'(busy),         64'h0);
    chk("rst_loaded",   64'(loaded),       64'h0);
    chk("rst_st_ready", 64'(st_ready),     64'h1);
    tick(0, 1, 1, 'h5A, 1, 'h5B, 0, 0, 1);
    chk("rst_st_ready_wr", 64'(st_ready),  64'h0);
    chk("rst_rd_data",     64'(rd_data),   64'h0);

    // Stream six words without commit; active stays zero
    for (int k = 0; k < M; k++) begin
      tick(1, 0, 0, 0, 1, (k + 1) * 'h11, 0, 0, 0);
      chk("stream_active_zero", 64'(all_data_out), 64'h0);
      if (k == M - 2) chk("loaded_before_6th", 64'(loaded), 64'h0);
    end
    chk("loaded_after_6th", 64'(loaded), 64'h1);
    tick(1, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("commit_copy", 64'(all_data_out), 64'h665544332211);

    // Write has priority over stream; commit excludes same-edge write
    tick(1, 1, 2, 'hAA, 1, 'h77, 0, 0, 2);
    chk("wr_blocks_stream", 64'(st_ready), 64'h0);
    tick(1, 0, 0, 0, 1, 'h77, 0, 1, 2);
    chk("stream_retry_ready", 64'(st_ready),     64'h1);
    chk("commit_with_wr",     64'(all_data_out), 64'h665544AA2211);
    chk("rd_addr2",           64'(rd_data),      64'hAA);
    chk("loaded_after_commit", 64'(loaded),      64'h1);

    // Out-of-range write and read
    tick(1, 1, 7, 'h55, 0, 0, 0, 0, 7);
    chk("rd_oob", 64'(rd_data), 64'h0);
    tick(1, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("oob_write_dropped", 64'(all_data_out), 64'h665544AA2277);

    // Clear sweep with commit arriving mid-sweep
    tick(1, 0, 0, 0, 0, 0, 1, 0, 0);
    bc = busy ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      tick(1, 0, 0, 0, 0, 0, 0, (k == 1), 3);
      if (busy) bc++;
    end
    chk("busy_cycles",        64'(bc),           64'd6);
    chk("pend_commit_zeroes", 64'(all_data_out), 64'h0);
    chk("loaded_after_clear", 64'(loaded),       64'h0);

    // Eight stream words: pointer wraps
    for (int k = 0; k < 8; k++) tick(1, 0, 0, 0, 1, 'h81 + k, 0, 0, 0);
    chk("wrap_loaded", 64'(loaded), 64'h1);
    tick(1, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("wrap_active", 64'(all_data_out), 64'h868584838887);
    chk("wrap_rd1",    64'(rd_data),      64'h88);

    // Reset mid-sweep with a pending commit
    tick(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("abort_all_data", 64'(all_data_out), 64'h0);
    chk("abort_busy",     64'(busy),         64'h0);
    chk("abort_loaded",   64'(loaded),       64'h0);
    chk("abort_st_ready", 64'(st_ready),     64'h1);
    for (int k = 0; k < 3; k++) tick(1, 0, 0, 0, 1, 'hC1 + k, 0, 0, 0);
    idle(8);
    chk("no_late_copy", 64'(all_data_out), 64'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      tick(($urandom % 40) != 0, ($urandom % 5) == 0, int'($urandom % 8), int'($urandom % 256),
           ($urandom % 2) == 0, int'($urandom % 256), ($urandom % 13) == 0,
           ($urandom % 5) == 0, int'($urandom % 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dbuf_memory.md
DBUF_MEMORY -- requirements
Module: dbuf_memory

Interface
REQ-001 Parameter M, default 320: number of entries; SHALL be 2 or greater.
REQ-002 Parameter N, default 8: bits per entry.
REQ-003 Localparam AW = $clog2(M): address width.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 wr_en  in  1  random-access write strobe into the shadow bank.
REQ-007 wr_addr  in  AW  random-access write address.
REQ-008 wr_data  in  N  random-access write data.
REQ-009 st_valid  in  1  stream-load word valid.
REQ-010 st_data  in  N  stream-load word.
REQ-011 st_ready  out  1  stream-load word accepted this cycle when high together with st_valid.
REQ-012 clear  in  1  one-cycle pulse that starts a shadow-bank clear sweep.
REQ-013 commit  in  1  one-cycle pulse that copies the shadow bank to the active bank.
REQ-014 rd_addr  in  AW  read address into the active bank.
REQ-015 rd_data  out  N  active[rd_addr], combinational; SHALL be 0 when rd_addr >= M.
REQ-016 all_data_out  out  M*N  active bank, with entry i on bits [i*N +: N].
REQ-017 busy  out  1  high while the clear sweep runs.
REQ-018 loaded  out  1  high once M words have been streamed since the last clear or reset.

Function
REQ-019 The block SHALL hold two M x N banks: shadow (written) and active (read); writes SHALL never alter active directly.
REQ-020 FSM states SHALL be IDLE and CLEAR; clear in IDLE SHALL go to CLEAR with sweep pointer 0.
REQ-021 In CLEAR, shadow[ptr] SHALL be written 0 each cycle, ptr SHALL increment, and the FSM SHALL return to IDLE after the cycle that clears entry M-1, taking exactly M cycles.
REQ-022 clear received while in CLEAR SHALL restart the sweep at entry 0.
REQ-023 busy SHALL equal (state == CLEAR).
REQ-024 A wr_en write SHALL take effect at the next edge and SHALL be dropped when busy is high or wr_addr >= M.
REQ-025 st_ready SHALL equal !busy && !wr_en; wr_en has priority over the stream in the same cycle.
REQ-026 An accepted stream word SHALL be written to shadow[st_ptr]; st_ptr SHALL then increment and wrap from M-1 to 0.
REQ-027 A stream count SHALL saturate at M; loaded SHALL be high when the count equals M.
REQ-028 Entering CLEAR SHALL zero st_ptr, the stream count and loaded.
REQ-029 commit in IDLE SHALL copy the whole shadow bank to active in one edge; the write landing on that same edge SHALL NOT be included in the copy.
REQ-030 commit while busy SHALL set commit_pend; the copy SHALL execute on the first IDLE cycle after the sweep, producing an all-zero active bank unless writes intervene; commit_pend SHALL then clear.
REQ-031 commit SHALL NOT change st_ptr, the stream count or loaded.
REQ-032 Simultaneous clear and commit in IDLE: commit SHALL copy the pre-clear shadow contents and the sweep SHALL start on the same edge.

Reset
REQ-033 With reset low at a clock edge: both banks SHALL be 0, state SHALL be IDLE, and ptr, st_ptr, the stream count, commit_pend and loaded SHALL be 0.
REQ-034 Reset values SHALL be: rd_data=0, all_data_out=0, busy=0, loaded=0, st_ready=!wr_en.
REQ-035 Reset asserted mid-sweep or mid-stream SHALL abort the operation with no residual pending commit.

Structure
REQ-036 A shared package snn_mem_pkg SHALL hold the FSM state typedef (ST_IDLE, ST_CLEAR).
REQ-037 One sub-module, dbuf_mem_bank (M x N register array with a write port and a flattened output), SHALL be instantiated twice, for shadow and active.

Verification (M=6, N=8)
REQ-038 Stream 0x11..0x66 with no commit: all_data_out SHALL stay 0 and loaded SHALL rise after the 6th word; then commit -> next cycle all_data_out = 0x665544332211.
REQ-039 wr_en at addr 2 with 0xAA together with st_valid: st_ready=0; after commit active[2] SHALL be 0xAA and the stream word SHALL be retried next cycle.
REQ-040 clear then commit on cycle 3: busy SHALL be high for exactly 6 cycles; active SHALL be all-zero on the cycle after busy falls.
REQ-041 wr_en with wr_addr=7 SHALL leave both banks unchanged; rd_addr=7 SHALL give rd_data=0.
REQ-042 Stream 8 words: st_ptr SHALL wrap and shadow[0..1] SHALL hold words 7..8; loaded=1.
REQ-043 Assert reset on cycle 2 of a sweep with commit_pend set: all outputs SHALL be at reset values and no later copy SHALL occur.
